periph_bus: RTL and testbench
=============================

PERIPH_BUS -- requirements
Module: periph_bus

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: peripheral slave channels, 1..16.
REQ-002 SHALL have parameter BASE_NIBBLE, default 4'h2: addr[31:28] value that selects the peripheral space.
REQ-003 SHALL have parameter PORT_SHIFT, default 12: LSB of the port index field in addr.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles before error, at least 2.
REQ-005 SHALL use one clock and a synchronous, active-high reset; clock port clk and reset port reset_i.
REQ-006 SHALL have clk  input  1  system clock.
REQ-007 SHALL have reset_i  input  1  synchronous active-high reset.
REQ-008 SHALL have req_i  input  1  CPU request strobe.
REQ-009 SHALL have addr_i  input  32  CPU byte address.
REQ-010 SHALL have we_i  input  1  1=write, 0=read.
REQ-011 SHALL have wr_mask_i  input  4  byte enables.
REQ-012 SHALL have wdata_i  input  32  CPU write data.
REQ-013 SHALL have rdata_o  output  32  read response data.
REQ-014 SHALL have ack_o  output  1  one-cycle completion pulse.
REQ-015 SHALL have err_o  output  1  error flag, qualified by ack_o.
REQ-016 SHALL have sel_o  output  NUM_PORTS  one-hot slave select.
REQ-017 SHALL have p_we_o  output  1  slave write enable.
REQ-018 SHALL have p_addr_o  output  PORT_SHIFT  offset within the port window.
REQ-019 SHALL have p_wdata_o  output  32  slave write data.
REQ-020 SHALL have p_wr_mask_o  output  4  slave byte enables.
REQ-021 SHALL have p_rdata_i  input  32*NUM_PORTS  slave read data, port k at bits [32k+31:32k].
REQ-022 SHALL have p_ack_i  input  NUM_PORTS  slave completion, one per port.

Function
REQ-023 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-024 In IDLE with req_i=1, SHALL latch addr, we, mask and wdata; req_i SHALL be ignored outside IDLE.
REQ-025 In IDLE with req_i=1, SHALL compute idx = addr_i[PORT_SHIFT+3:PORT_SHIFT].
REQ-026 If addr_i[31:28]!=BASE_NIBBLE or idx>=NUM_PORTS, SHALL go to RESP with err=1 and assert no sel_o (decode error).
REQ-027 Otherwise SHALL go to ACCESS.
REQ-028 In ACCESS, SHALL drive sel_o[idx]=1 every cycle and hold p_* outputs stable until exit.
REQ-029 p_addr_o SHALL be the latched addr[PORT_SHIFT-1:0].
REQ-030 On p_ack_i[idx]=1 in ACCESS: read SHALL register p_rdata_i for port idx; write SHALL register 0; then go to RESP with err=0.
REQ-031 p_ack_i bits for non-selected ports SHALL be ignored.
REQ-032 In RESP, SHALL assert ack_o for exactly one cycle and return to IDLE.
REQ-033 rdata_o and err_o SHALL be held until the next RESP.
REQ-034 Best-case latency SHALL be 2 cycles (ack_o in cycle 2 after req_i in cycle 0, slave ack in cycle 1); a decode error SHALL give ack_o in cycle 1.
REQ-035 ACCESS timeout is compiled per REQ-039.
REQ-036 Write-only masks SHALL pass through unchanged; no read-modify-write.

Reset
REQ-037 On reset_i, SHALL go to IDLE and clear sel_o, p_we_o, ack_o, err_o, rdata_o, the timeout counter and the latched request, all at the next clk edge.
REQ-038 Reset mid-ACCESS SHALL abort without ack_o, and sel_o SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-039 With PERIPH_BUS_TIMEOUT_EN defined: a counter of $clog2(TIMEOUT_CYCLES+1) bits SHALL count ACCESS cycles; on reaching TIMEOUT_CYCLES without ack, SHALL drop sel_o, go to RESP with err=1 and rdata_o=32'h0; the counter SHALL clear on ACCESS entry.
REQ-040 Without PERIPH_BUS_TIMEOUT_EN: SHALL have no counter, and ACCESS SHALL wait for ack indefinitely.

Structure
REQ-041 SHALL place in shared package soc_pkg: the FSM state enum periph_bus_state_t, PERIPH_BUS_MAX_PORTS=16, and the error read value constant.
REQ-042 SHALL instantiate one sub-module periph_decode (combinational address -> idx/valid), reusable by the SoC memory map.

Verification
REQ-043 Read port 1 at 0x2000_1004, slave acks in 1 cycle with 0x1234_5678 -> sel_o=4'b0010 for 1 cycle, p_addr_o=12'h004, ack_o at cycle 2, rdata_o=0x1234_5678, err_o=0.
REQ-044 Write 0xA5 mask 4'b0001 to 0x2000_3000, slave acks after 3 cycles -> p_we_o=1, p_wdata_o stable for 3 cycles, ack_o one pulse, err_o=0.
REQ-045 Read 0x2000_5000 (idx 5, NUM_PORTS=4) and read 0x3000_0000 -> no sel_o, ack_o at cycle 1, err_o=1.
REQ-046 With PERIPH_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks -> sel_o high for 16 cycles, then ack_o with err_o=1 and rdata_o=0.
REQ-047 reset_i asserted on the 2nd ACCESS cycle -> sel_o=0 next cycle, no ack_o, next request served normally.
REQ-048 req_i pulsed again during ACCESS, plus p_ack_i on a non-selected port -> both ignored, exactly one ack_o.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared SoC definitions: peripheral bus FSM states, port limit and error read value.
package soc_pkg;

  localparam int unsigned PERIPH_BUS_MAX_PORTS = 16;
  localparam logic [31:0] PERIPH_BUS_ERR_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } periph_bus_state_t;

endpackage

// File: rtl/periph_decode.sv
// Combinational peripheral address decode: port index field and in-range flag.
module periph_decode
  import soc_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter logic [3:0]  BASE_NIBBLE = 4'h2,
  parameter int unsigned PORT_SHIFT  = 12
) (
  input  logic [31:0] addr_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  if (NUM_PORTS < 1 || NUM_PORTS > PERIPH_BUS_MAX_PORTS) begin : g_bad_ports
    $error("periph_decode: NUM_PORTS out of range");
  end

  assign idx_o   = addr_i[PORT_SHIFT +: 4];
  assign valid_o = (addr_i[31:28] == BASE_NIBBLE) && ({28'd0, idx_o} < NUM_PORTS);

  // Offset bits are consumed by the bus, not the decoder.
  logic unused_addr;
  assign unused_addr = ^addr_i;

endmodule

// File: rtl/periph_bus.sv
// CPU-to-peripheral bridge: decode, one-hot slave select, single-beat transfer.
// Optional ACCESS timeout enabled by defining PERIPH_BUS_TIMEOUT_EN.
module periph_bus
  import soc_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter logic [3:0]  BASE_NIBBLE    = 4'h2,
  parameter int unsigned PORT_SHIFT     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    req_i,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [3:0]              wr_mask_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic [NUM_PORTS-1:0]    sel_o,
  output logic                    p_we_o,
  output logic [PORT_SHIFT-1:0]   p_addr_o,
  output logic [31:0]             p_wdata_o,
  output logic [3:0]              p_wr_mask_o,
  input  logic [32*NUM_PORTS-1:0] p_rdata_i,
  input  logic [NUM_PORTS-1:0]    p_ack_i
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("periph_bus: TIMEOUT_CYCLES must be at least 2");
  end

  periph_bus_state_t     state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic                  we_q, we_d;
  logic [3:0]            mask_q, mask_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [PORT_SHIFT-1:0] paddr_q, paddr_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [3:0]            dec_idx;
  logic                  dec_valid;
  logic [NUM_PORTS-1:0]  port_sel;
  logic [31:0]           slave_rdata;
  logic                  slave_ack;
  logic                  timeout;

  periph_decode #(
    .NUM_PORTS  (NUM_PORTS),
    .BASE_NIBBLE(BASE_NIBBLE),
    .PORT_SHIFT (PORT_SHIFT)
  ) u_decode (
    .addr_i (addr_i),
    .idx_o  (dec_idx),
    .valid_o(dec_valid)
  );

  always_comb begin
    port_sel    = '0;
    slave_rdata = '0;
    for (int k = 0; k < int'(NUM_PORTS); k++) begin
      if (idx_q == 4'(k)) begin
        port_sel[k] = 1'b1;
        slave_rdata = p_rdata_i[32*k +: 32];
      end
    end
  end

  // Acks from ports other than the latched one are masked off here.
  assign slave_ack = |(p_ack_i & port_sel);

`ifdef PERIPH_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Held at zero outside ACCESS, so every ACCESS entry starts from zero.
  always_comb begin
    cnt_d = '0;
    if (state_q == StAccess) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign timeout = (state_q == StAccess) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    paddr_d = paddr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          idx_d   = dec_idx;
          we_d    = we_i;
          mask_d  = wr_mask_i;
          wdata_d = wdata_i;
          paddr_d = addr_i[PORT_SHIFT-1:0];
          if (dec_valid) begin
            state_d = StAccess;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = PERIPH_BUS_ERR_RDATA;
          end
        end
      end
      StAccess: begin
        if (slave_ack) begin
          state_d = StResp;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : slave_rdata;
        end else if (timeout) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = PERIPH_BUS_ERR_RDATA;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      paddr_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      paddr_q <= paddr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign sel_o       = (state_q == StAccess) ? port_sel : '0;
  assign p_we_o      = (state_q == StAccess) && we_q;
  assign p_addr_o    = paddr_q;
  assign p_wdata_o   = wdata_q;
  assign p_wr_mask_o = mask_q;
  assign ack_o       = (state_q == StResp);
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_periph_bus.sv
// Randomized bench for periph_bus against a transaction-level reference model.
module tb_periph_bus;

  localparam int unsigned NP = 4;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            req_i;
  logic [31:0]     addr_i;
  logic            we_i;
  logic [3:0]      wr_mask_i;
  logic [31:0]     wdata_i;
  logic [31:0]     rdata_o;
  logic            ack_o;
  logic            err_o;
  logic [NP-1:0]   sel_o;
  logic            p_we_o;
  logic [11:0]     p_addr_o;
  logic [31:0]     p_wdata_o;
  logic [3:0]      p_wr_mask_o;
  logic [32*NP-1:0] p_rdata_i;
  logic [NP-1:0]   p_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  periph_bus #(
    .NUM_PORTS     (NP),
    .BASE_NIBBLE   (4'h2),
    .PORT_SHIFT    (12),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .wr_mask_i  (wr_mask_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .sel_o      (sel_o),
    .p_we_o     (p_we_o),
    .p_addr_o   (p_addr_o),
    .p_wdata_o  (p_wdata_o),
    .p_wr_mask_o(p_wr_mask_o),
    .p_rdata_i  (p_rdata_i),
    .p_ack_i    (p_ack_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference decode straight from the address map rules.
  function automatic bit model_valid(input logic [31:0] a);
    return ((a >> 28) == 32'h2) && (((a >> 12) & 32'hF) < NP);
  endfunction

  task automatic scramble_rdata();
    for (int k = 0; k < int'(NP); k++) p_rdata_i[32*k +: 32] = $urandom;
  endtask

  // Starts and ends just after a rising edge. lat = slave ack cycle (>=1).
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] mask,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rd,
                         input bit noise);
    int idx;
    bit ok;
    idx = int'((addr >> 12) & 32'hF);
    ok  = model_valid(addr);
    req_i = 1'b1; addr_i = addr; we_i = we; wr_mask_i = mask; wdata_i = wdata;
    next_cycle();
    req_i = 1'b0;
    if (!ok) begin
      @(negedge clk);
      check_eq("dec_ack", 32'(ack_o), 32'd1);
      check_eq("dec_err", 32'(err_o), 32'd1);
      check_eq("dec_sel", 32'(sel_o), 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("dec_ack_end", 32'(ack_o), 32'd0);
      check_eq("dec_err_hold", 32'(err_o), 32'd1);
      next_cycle();
      return;
    end
    for (int c = 1; c <= lat; c++) begin
      scramble_rdata();
      p_ack_i = '0;
      if (noise) begin
        p_ack_i = NP'($urandom);
        req_i   = 1'($urandom);
        addr_i  = $urandom;
        wdata_i = $urandom;
        we_i    = 1'($urandom);
      end
      p_ack_i[idx] = (c == lat);
      if (c == lat) p_rdata_i[32*idx +: 32] = rd;
      @(negedge clk);
      check_eq("sel", 32'(sel_o), 32'd1 << idx);
      check_eq("p_we", 32'(p_we_o), 32'(we));
      check_eq("p_addr", 32'(p_addr_o), addr & 32'hFFF);
      check_eq("p_wdata", p_wdata_o, wdata);
      check_eq("p_mask", 32'(p_wr_mask_o), 32'(mask));
      check_eq("early_ack", 32'(ack_o), 32'd0);
      next_cycle();
      req_i = 1'b0;
      p_ack_i = '0;
    end
    @(negedge clk);
    check_eq("resp_ack", 32'(ack_o), 32'd1);
    check_eq("resp_err", 32'(err_o), 32'd0);
    check_eq("resp_rdata", rdata_o, we ? 32'h0 : rd);
    check_eq("resp_sel", 32'(sel_o), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("ack_single", 32'(ack_o), 32'd0);
    check_eq("rdata_hold", rdata_o, we ? 32'h0 : rd);
    next_cycle();
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  nib;
    logic [3:0]  pidx;

    reset_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wr_mask_i = '0;
    wdata_i = '0; p_rdata_i = '0; p_ack_i = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_ack", 32'(ack_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_sel", 32'(sel_o), 32'd0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    check_eq("rst_p_we", 32'(p_we_o), 32'd0);
    next_cycle();
    reset_i = 1'b0;

    run_txn(32'h2000_1004, 1'b0, 4'hF, 32'h0, 1, 32'h1234_5678, 1'b0);
    run_txn(32'h2000_3000, 1'b1, 4'b0001, 32'h0000_00A5, 3, 32'hDEAD_BEEF, 1'b0);
    run_txn(32'h2000_5000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 1'b0);
    run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 1'b0);
    run_txn(32'h2000_2ABC, 1'b0, 4'hF, 32'h0, 3, 32'hCAFE_F00D, 1'b1);

    // Reset on the second ACCESS cycle aborts the transfer.
    req_i = 1'b1; addr_i = 32'h2000_2010; we_i = 1'b0; wr_mask_i = 4'hF;
    next_cycle();
    req_i = 1'b0;
    @(negedge clk);
    check_eq("abort_sel1", 32'(sel_o), 32'd4);
    next_cycle();
    reset_i = 1'b1;
    @(negedge clk);
    check_eq("abort_sel2", 32'(sel_o), 32'd4);
    next_cycle();
    reset_i = 1'b0;
    @(negedge clk);
    check_eq("abort_sel", 32'(sel_o), 32'd0);
    check_eq("abort_ack", 32'(ack_o), 32'd0);
    check_eq("abort_rdata", rdata_o, 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("abort_no_ack", 32'(ack_o), 32'd0);
    next_cycle();
    run_txn(32'h2000_0008, 1'b0, 4'hF, 32'h0, 2, 32'h5555_AAAA, 1'b0);

    for (int t = 0; t < 40; t++) begin
      nib  = 4'h2;
      pidx = 4'($urandom_range(0, NP - 1));
      case ($urandom_range(0, 9))
        0: nib = 4'($urandom_range(3, 15));
        1: pidx = 4'($urandom_range(NP, 15));
        default: ;
      endcase
      a = {nib, 12'($urandom), pidx, 12'($urandom)};
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, int'($urandom_range(1, 6)),
              $urandom, 1'($urandom));
    end

`ifdef PERIPH_BUS_TIMEOUT_EN
    run_txn(32'h2000_0000, 1'b0, 4'hF, 32'h0, 1, 32'h7777_1111, 1'b0);
    req_i = 1'b1; addr_i = 32'h2000_0000; we_i = 1'b0; wr_mask_i = 4'hF;
    next_cycle();
    req_i = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check_eq("to_sel", 32'(sel_o), 32'd1);
      check_eq("to_no_ack", 32'(ack_o), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check_eq("to_ack", 32'(ack_o), 32'd1);
    check_eq("to_err", 32'(err_o), 32'd1);
    check_eq("to_rdata", rdata_o, 32'd0);
    check_eq("to_sel_drop", 32'(sel_o), 32'd0);
    next_cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
